// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: write-back source encodings, load
// funct3 codes and the write-back FSM state type.
package riscv_pkg;

  localparam logic [1:0] WB_MEM  = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_ALU2 = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // x0 is hardwired to zero, so a write to it is never issued.
  function automatic logic rd_writes(input logic regwen, input logic [4:0] rd);
    return regwen && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load formatter: picks the addressed byte/half out of an aligned memory
// word and sign- or zero-extends it according to funct3.
module load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_module.sv
// Write-back stage: registers ALU/PC+4 results or formatted load data onto
// the register-file write port, stalling upstream while a load is pending.
module wb_module
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic        MEM_IsLoad,
  input  logic        MEM_RegWEn,
  input  logic [1:0]  MEM_WBSel,
  input  logic [2:0]  MEM_Funct3,
  input  logic [31:0] MEM_Alu,
  input  logic [31:0] MEM_PC,
  input  logic [4:0]  MEM_AddrD,
  input  logic        DMEM_rvalid,
  input  logic [31:0] DMEM_rdata,
  output logic [31:0] WB_DataD,
  output logic [4:0]  WB_AddrD,
  output logic        WB_RegWEn,
  output logic        WB_Stall,
  output logic        WB_Err
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_addrd;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic             r_regwen;
  logic [1:0]       r_wbsel;
  logic [31:0]      r_cand;

  logic [31:0]      w_cand;
  logic [31:0]      w_load_data;
  logic [31:0]      w_resp_data;

  assign w_cand = (MEM_WBSel == WB_PC4) ? (MEM_PC + 32'd4) : MEM_Alu;

  load_ext u_load_ext (
    .i_rdata  (DMEM_rdata),
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .o_data   (w_load_data)
  );

  // A load with a non-memory source still retires its latched candidate.
  assign w_resp_data = (r_wbsel == WB_MEM) ? w_load_data : r_cand;

  assign WB_Stall = (r_state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addrd   <= 5'd0;
      r_funct3  <= 3'd0;
      r_off     <= 2'd0;
      r_regwen  <= 1'b0;
      r_wbsel   <= 2'd0;
      r_cand    <= 32'd0;
      WB_DataD  <= 32'd0;
      WB_AddrD  <= 5'd0;
      WB_RegWEn <= 1'b0;
      WB_Err    <= 1'b0;
    end else begin
      WB_RegWEn <= 1'b0;
      case (r_state)
        IDLE: begin
          if (MEM_valid) begin
            r_addrd  <= MEM_AddrD;
            r_funct3 <= MEM_Funct3;
            r_off    <= MEM_Alu[1:0];
            r_regwen <= MEM_RegWEn;
            r_wbsel  <= MEM_WBSel;
            r_cand   <= w_cand;
            if (MEM_IsLoad) begin
              r_state <= WAIT;
              r_cnt   <= '0;
            end else if (rd_writes(MEM_RegWEn, MEM_AddrD)) begin
              WB_RegWEn <= 1'b1;
              WB_DataD  <= w_cand;
              WB_AddrD  <= MEM_AddrD;
            end
          end
        end
        WAIT: begin
          // A response on the final timeout edge takes priority over the abort.
          if (DMEM_rvalid) begin
            r_state <= IDLE;
            if (rd_writes(r_regwen, r_addrd)) begin
              WB_RegWEn <= 1'b1;
              WB_DataD  <= w_resp_data;
              WB_AddrD  <= r_addrd;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            WB_Err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_module.sv
// Directed bench for wb_module: cycle-by-cycle comparison against a
// transaction-level model plus hand-computed expectations.
module tb_wb_module;

  localparam int TO = 16;

  logic        clk, rst;
  logic        MEM_valid, MEM_IsLoad, MEM_RegWEn;
  logic [1:0]  MEM_WBSel;
  logic [2:0]  MEM_Funct3;
  logic [31:0] MEM_Alu, MEM_PC;
  logic [4:0]  MEM_AddrD;
  logic        DMEM_rvalid;
  logic [31:0] DMEM_rdata;
  logic [31:0] WB_DataD;
  logic [4:0]  WB_AddrD;
  logic        WB_RegWEn, WB_Stall, WB_Err;

  int checks = 0;
  int failures = 0;

  wb_module #(.LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_IsLoad(MEM_IsLoad), .MEM_RegWEn(MEM_RegWEn),
    .MEM_WBSel(MEM_WBSel), .MEM_Funct3(MEM_Funct3), .MEM_Alu(MEM_Alu),
    .MEM_PC(MEM_PC), .MEM_AddrD(MEM_AddrD),
    .DMEM_rvalid(DMEM_rvalid), .DMEM_rdata(DMEM_rdata),
    .WB_DataD(WB_DataD), .WB_AddrD(WB_AddrD), .WB_RegWEn(WB_RegWEn),
    .WB_Stall(WB_Stall), .WB_Err(WB_Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected load result from the architectural definition of each load.
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic [31:0] v;
    v = w;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> (off >= 2'd2 ? 16 : 0)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Model state: one outstanding load at most, aged in cycles since acceptance.
  bit          m_pending;
  int          m_age;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic        m_wen;
  logic [1:0]  m_sel;
  logic [31:0] m_cand;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  logic        e_wen, e_err;

  task automatic model_step();
    e_wen = 1'b0;
    if (rst) begin
      m_pending = 0; m_age = 0; e_data = 0; e_addr = 0; e_err = 0;
    end else if (!m_pending) begin
      if (MEM_valid) begin
        m_rd = MEM_AddrD; m_f3 = MEM_Funct3; m_off = MEM_Alu[1:0];
        m_wen = MEM_RegWEn; m_sel = MEM_WBSel;
        m_cand = (MEM_WBSel == 2'd2) ? MEM_PC + 32'd4 : MEM_Alu;
        if (MEM_IsLoad) begin
          m_pending = 1; m_age = 0;
        end else if (MEM_RegWEn && MEM_AddrD != 0) begin
          e_wen = 1; e_data = m_cand; e_addr = MEM_AddrD;
        end
      end
    end else begin
      m_age++;
      if (DMEM_rvalid) begin
        m_pending = 0;
        if (m_wen && m_rd != 0) begin
          e_wen = 1; e_addr = m_rd;
          e_data = (m_sel == 2'd0) ? fmt(DMEM_rdata, m_f3, m_off) : m_cand;
        end
      end else if (m_age == TO) begin
        m_pending = 0; e_err = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cycle", {WB_DataD, WB_AddrD, WB_RegWEn, WB_Stall, WB_Err},
          {e_data, e_addr, e_wen, logic'(m_pending), e_err});
    end
  end

  task automatic clear_in();
    MEM_valid = 0; MEM_IsLoad = 0; MEM_RegWEn = 0; MEM_WBSel = 2'd1;
    MEM_Funct3 = 3'd0; MEM_Alu = 0; MEM_PC = 0; MEM_AddrD = 0;
    DMEM_rvalid = 0;
  endtask

  // Present one instruction for exactly one cycle; leaves the bench one cycle later.
  task automatic issue(input logic ld, input logic wen, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] rd);
    @(negedge clk);
    MEM_valid = 1; MEM_IsLoad = ld; MEM_RegWEn = wen; MEM_WBSel = sel;
    MEM_Funct3 = f3; MEM_Alu = alu; MEM_PC = pc; MEM_AddrD = rd;
    @(negedge clk);
    clear_in();
  endtask

  // Load whose response is sampled d edges after acceptance (d = 0: none).
  // A junk ALU op is offered while waiting to show it is ignored.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata, input int d,
                         input logic [31:0] exp_data);
    int stall_n;
    int lim;
    stall_n = 0;
    lim = (d == 0) ? TO : d;
    issue(1'b1, 1'b1, 2'd0, f3, addr, 32'h0, rd);
    for (int i = 1; i <= lim; i++) begin
      if (WB_Stall) stall_n++;
      MEM_valid = 1; MEM_RegWEn = 1; MEM_AddrD = 5'd9; MEM_Alu = 32'h0BAD_0BAD;
      if (i == d) begin
        DMEM_rvalid = 1; DMEM_rdata = rdata;
      end
      @(negedge clk);
      clear_in();
    end
    chk({name, "_stall_cycles"}, 40'(stall_n), 40'(lim));
    chk({name, "_stall_low"}, 40'(WB_Stall), 40'd0);
    chk({name, "_wen"}, 40'(WB_RegWEn), (d == 0) ? 40'd0 : 40'd1);
    chk({name, "_data"}, 40'(WB_DataD), 40'(exp_data));
  endtask

  initial begin
    rst = 1;
    clear_in();
    DMEM_rdata = 0;
    @(posedge clk); #2;
    chk("reset_state", {WB_DataD, WB_AddrD, WB_RegWEn, WB_Stall, WB_Err}, 40'd0);
    @(negedge clk);
    rst = 0;

    issue(1'b0, 1'b1, 2'd1, 3'd0, 32'h1234_5678, 32'h100, 5'd5);
    chk("alu_wen", 40'(WB_RegWEn), 40'd1);
    chk("alu_addr", 40'(WB_AddrD), 40'd5);
    chk("alu_data", 40'(WB_DataD), 40'h0012345678);
    @(negedge clk);
    chk("pulse_one_cycle", 40'(WB_RegWEn), 40'd0);

    issue(1'b0, 1'b1, 2'd1, 3'd0, 32'h0000_DEAD, 32'h104, 5'd0);
    chk("rd0_no_write", 40'(WB_RegWEn), 40'd0);
    chk("rd0_hold_data", 40'(WB_DataD), 40'h0012345678);
    issue(1'b0, 1'b0, 2'd3, 3'd0, 32'h0000_BEEF, 32'h108, 5'd6);
    chk("regwen0_no_write", 40'(WB_RegWEn), 40'd0);

    // Back-to-back ALU ops.
    @(negedge clk);
    MEM_valid = 1; MEM_RegWEn = 1; MEM_WBSel = 2'd3; MEM_Alu = 32'hA; MEM_AddrD = 5'd1;
    @(negedge clk);
    chk("b2b_first", {WB_DataD, WB_AddrD, WB_RegWEn}, {32'hA, 5'd1, 1'b1, 2'b00} >> 2);
    MEM_Alu = 32'hB; MEM_AddrD = 5'd2;
    @(negedge clk);
    clear_in();
    chk("b2b_second", {WB_DataD, WB_AddrD, WB_RegWEn}, {32'hB, 5'd2, 1'b1, 2'b00} >> 2);

    issue(1'b0, 1'b1, 2'd2, 3'd0, 32'h5555_5555, 32'hFFFF_FFFC, 5'd1);
    chk("jal_wrap", 40'(WB_DataD), 40'h0);
    chk("jal_wen", 40'(WB_RegWEn), 40'd1);

    // DMEM response while idle must not write.
    @(negedge clk);
    DMEM_rvalid = 1; DMEM_rdata = 32'h7777_7777;
    @(negedge clk);
    clear_in();
    chk("idle_rvalid_ignored", 40'(WB_RegWEn), 40'd0);

    do_load("lb3",  3'b000, 32'h0000_1003, 5'd7,  32'h80AB_CDEF, 3,  32'hFFFF_FF80);
    do_load("lhu2", 3'b101, 32'h0000_1002, 5'd8,  32'h80AB_CDEF, 2,  32'h0000_80AB);
    do_load("lh0",  3'b001, 32'h0000_1000, 5'd10, 32'h80AB_CDEF, 1,  32'hFFFF_CDEF);
    do_load("lbu1", 3'b100, 32'h0000_1001, 5'd11, 32'h80AB_CDEF, 4,  32'h0000_00CD);
    do_load("lw",   3'b010, 32'h0000_1000, 5'd12, 32'h80AB_CDEF, 2,  32'h80AB_CDEF);
    do_load("lastcyc", 3'b010, 32'h0000_1000, 5'd13, 32'hCAFE_F00D, TO, 32'hCAFE_F00D);
    chk("lastcyc_no_err", 40'(WB_Err), 40'd0);

    do_load("timeout", 3'b010, 32'h0000_1000, 5'd14, 32'h0, 0, 32'hCAFE_F00D);
    chk("timeout_err", 40'(WB_Err), 40'd1);
    issue(1'b0, 1'b1, 2'd1, 3'd0, 32'h0000_0042, 32'h0, 5'd15);
    chk("after_timeout_write", {WB_DataD, WB_AddrD, WB_RegWEn}, {32'h42, 5'd15, 1'b1, 2'b00} >> 2);
    chk("err_sticky", 40'(WB_Err), 40'd1);

    // Reset two cycles after a load is accepted.
    issue(1'b1, 1'b1, 2'd0, 3'b010, 32'h0000_2000, 32'h0, 5'd3);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_wait_outputs", {WB_DataD, WB_AddrD, WB_RegWEn, WB_Stall, WB_Err}, 40'd0);
    @(negedge clk);
    rst = 0;
    DMEM_rvalid = 1; DMEM_rdata = 32'h1111_2222;
    @(negedge clk);
    clear_in();
    chk("rst_drop_load", {WB_DataD, WB_AddrD, WB_RegWEn, WB_Stall}, 40'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
